// File: rtl/mem_port_arbiter.sv
// Arbitrates the single AXI memory port between instruction fetch and load/store,
// holding each granted request until mem_ready and buffering the returned data.
module mem_port_arbiter #(
    parameter bit KSEG_MAP   = 1'b1,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    input  logic        pipe_adv,
    input  logic        flush,
    output logic        stallreq_from_if,
    output logic        stallreq_from_mem,
    output logic [31:0] mem_a,
    output logic        mem_access,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_st_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        r_i_done;
    logic        r_d_done;
    logic        r_discard;
    logic        r_mem_access;
    logic        r_mem_write;
    logic [1:0]  r_mem_size;
    logic [3:0]  r_mem_sel;
    logic [31:0] r_mem_a;
    logic [31:0] r_mem_st_data;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        w_i_pend;
    logic        w_d_pend;
    logic        w_busy;
    logic        w_i_cpl;
    logic        w_d_cpl;

    // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical memory
    function automatic logic [31:0] map_addr(input logic [31:0] addr);
        logic [31:0] res;
        if (KSEG_MAP && ((addr[31:29] == 3'b100) || (addr[31:29] == 3'b101))) begin
            res = {3'b000, addr[28:0]};
        end else begin
            res = addr;
        end
        return res;
    endfunction

    assign w_d_pend = d_req & ~r_d_done & ~flush;
    assign w_i_pend = i_req & ~r_i_done;
    assign w_busy   = (r_state != IDLE);
    assign w_i_cpl  = (r_state == I_BUSY) & mem_ready;
    assign w_d_cpl  = (r_state == D_BUSY) & mem_ready;

    // Grant selection and state sequencing
    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_d_pend && (DATA_FIRST || !w_i_pend)) begin
                    w_grant_d    = 1'b1;
                    w_next_state = D_BUSY;
                end else if (w_i_pend) begin
                    w_grant_i    = 1'b1;
                    w_next_state = I_BUSY;
                end else begin
                    w_next_state = IDLE;
                end
            end
            I_BUSY:  w_next_state = mem_ready ? IDLE : I_BUSY;
            D_BUSY:  w_next_state = mem_ready ? IDLE : D_BUSY;
            default: w_next_state = IDLE;
        endcase
    end

    // State register and memory-port payload, frozen while a beat is outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_mem_access  <= 1'b0;
            r_mem_a       <= 32'd0;
            r_mem_write   <= 1'b0;
            r_mem_size    <= 2'd0;
            r_mem_sel     <= 4'd0;
            r_mem_st_data <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_d) begin
                r_mem_access  <= 1'b1;
                r_mem_a       <= map_addr(d_addr);
                r_mem_write   <= d_write;
                r_mem_size    <= d_size;
                r_mem_sel     <= d_sel;
                r_mem_st_data <= d_wdata;
            end else if (w_grant_i) begin
                r_mem_access <= 1'b1;
                r_mem_a      <= map_addr(i_addr);
                r_mem_write  <= 1'b0;
                r_mem_size   <= 2'b10;
                r_mem_sel    <= 4'b1111;
            end else if (w_busy && mem_ready) begin
                r_mem_access <= 1'b0;
            end
        end
    end

    // Done flags stay set until the pipeline advances so completed work is not re-issued
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_discard <= 1'b0;
            r_i_rdata <= 32'd0;
            r_d_rdata <= 32'd0;
        end else begin
            if (pipe_adv) begin
                r_i_done <= 1'b0;
            end else if (w_i_cpl && !r_discard) begin
                r_i_done <= 1'b1;
            end
            if (pipe_adv || flush) begin
                r_d_done <= 1'b0;
            end else if (w_d_cpl && !r_discard) begin
                r_d_done <= 1'b1;
            end
            if (w_busy && mem_ready) begin
                r_discard <= 1'b0;
            end else if (w_busy && flush) begin
                r_discard <= 1'b1;
            end
            if (w_i_cpl) begin
                r_i_rdata <= mem_data;
            end
            if (w_d_cpl && !r_mem_write) begin
                r_d_rdata <= mem_data;
            end
        end
    end

    assign stallreq_from_if  = i_req & ~r_i_done;
    assign stallreq_from_mem = d_req & ~r_d_done & ~flush;
    assign mem_access        = r_mem_access;
    assign mem_a             = r_mem_a;
    assign mem_write         = r_mem_write;
    assign mem_size          = r_mem_size;
    assign mem_sel           = r_mem_sel;
    assign mem_st_data       = r_mem_st_data;
    assign i_rdata           = r_i_rdata;
    assign d_rdata           = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single data accesses
// plus hand-written fetch, arbitration, flush and reset sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst, i_req, d_req, d_write, pipe_adv, flush, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_data;
    logic [1:0]  d_size;
    logic [3:0]  d_sel;
    logic [31:0] i_rdata, d_rdata, mem_a, mem_st_data;
    logic        stallreq_from_if, stallreq_from_mem, mem_access, mem_write;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] reply;
        int          waits;
        logic [31:0] exp_a;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_sel(d_sel),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .pipe_adv(pipe_adv), .flush(flush),
        .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem),
        .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
        .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
        .mem_ready(mem_ready), .mem_data(mem_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_access(input string name);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_access === 1'b1) break;
        end
        chk({name, " access"}, {31'd0, mem_access}, 32'd1);
    endtask

    task automatic reply(input logic [31:0] data);
        mem_ready = 1'b1;
        mem_data  = data;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_data  = 32'd0;
        #1;
    endtask

    task automatic advance();
        i_req    = 1'b0;
        d_req    = 1'b0;
        pipe_adv = 1'b1;
        @(negedge clk);
        pipe_adv = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        //        write size   sel      addr          wdata         reply         w  exp_a         exp_rdata
        vecs[0] = '{1'b0, 2'd2, 4'b1111, 32'h8000_0010, 32'h0000_0000, 32'h1234_5678, 0, 32'h0000_0010, 32'h1234_5678};
        vecs[1] = '{1'b1, 2'd0, 4'b0100, 32'hBFAF_F000, 32'h00AB_0000, 32'hFFFF_FFFF, 5, 32'h1FAF_F000, 32'h1234_5678};
        vecs[2] = '{1'b0, 2'd1, 4'b0011, 32'hC000_0000, 32'h0000_0000, 32'hCAFE_BEEF, 2, 32'hC000_0000, 32'hCAFE_BEEF};
        vecs[3] = '{1'b0, 2'd2, 4'b1111, 32'h0000_1000, 32'h0000_0000, 32'hDEAD_0001, 1, 32'h0000_1000, 32'hDEAD_0001};

        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; pipe_adv = 1'b0;
        flush = 1'b0; mem_ready = 1'b0; i_addr = 32'd0; d_addr = 32'd0;
        d_wdata = 32'd0; mem_data = 32'd0; d_size = 2'd0; d_sel = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset access", {31'd0, mem_access}, 32'd0);
        chk("reset mem_a", mem_a, 32'd0);
        chk("reset i_rdata", i_rdata, 32'd0);
        rst = 1'b0;

        // Fetch only, three wait cycles
        i_req = 1'b1; i_addr = 32'hBFC0_0000;
        wait_access("fetch");
        chk("fetch mem_a", mem_a, 32'h1FC0_0000);
        chk("fetch sel", {28'd0, mem_sel}, 32'hF);
        chk("fetch size", {30'd0, mem_size}, 32'd2);
        chk("fetch write", {31'd0, mem_write}, 32'd0);
        for (int w = 0; w < 3; w++) begin
            chk("fetch stall", {31'd0, stallreq_from_if}, 32'd1);
            @(negedge clk);
            chk("fetch hold", {31'd0, mem_access}, 32'd1);
        end
        reply(32'h2408_0001);
        chk("fetch stall rel", {31'd0, stallreq_from_if}, 32'd0);
        chk("fetch i_rdata", i_rdata, 32'h2408_0001);
        chk("fetch access drop", {31'd0, mem_access}, 32'd0);
        advance();

        // Table of single data accesses
        for (int v = 0; v < 4; v++) begin
            d_req = 1'b1; d_write = vecs[v].write; d_size = vecs[v].size;
            d_sel = vecs[v].sel; d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
            wait_access($sformatf("v%0d", v));
            chk($sformatf("v%0d mem_a", v), mem_a, vecs[v].exp_a);
            chk($sformatf("v%0d write", v), {31'd0, mem_write}, {31'd0, vecs[v].write});
            chk($sformatf("v%0d size", v), {30'd0, mem_size}, {30'd0, vecs[v].size});
            chk($sformatf("v%0d sel", v), {28'd0, mem_sel}, {28'd0, vecs[v].sel});
            chk($sformatf("v%0d st_data", v), mem_st_data, vecs[v].wdata);
            for (int w = 0; w < vecs[v].waits; w++) begin
                @(negedge clk);
                chk($sformatf("v%0d hold a", v), mem_a, vecs[v].exp_a);
                chk($sformatf("v%0d hold st", v), mem_st_data, vecs[v].wdata);
                chk($sformatf("v%0d hold acc", v), {31'd0, mem_access}, 32'd1);
                chk($sformatf("v%0d stall", v), {31'd0, stallreq_from_mem}, 32'd1);
            end
            reply(vecs[v].reply);
            chk($sformatf("v%0d stall rel", v), {31'd0, stallreq_from_mem}, 32'd0);
            chk($sformatf("v%0d acc drop", v), {31'd0, mem_access}, 32'd0);
            chk($sformatf("v%0d d_rdata", v), d_rdata, vecs[v].exp_rdata);
            advance();
        end
        @(negedge clk);
        chk("idle hold mem_a", mem_a, 32'h0000_1000);
        chk("idle access", {31'd0, mem_access}, 32'd0);

        // Simultaneous requests: data first, then fetch, then sticky done
        d_req = 1'b1; d_write = 1'b0; d_size = 2'd2; d_sel = 4'hF; d_addr = 32'h8000_0010;
        i_req = 1'b1; i_addr = 32'h8000_0200;
        wait_access("sim d");
        chk("sim first a", mem_a, 32'h0000_0010);
        reply(32'h1111_1111);
        chk("sim d stall", {31'd0, stallreq_from_mem}, 32'd0);
        chk("sim i stall", {31'd0, stallreq_from_if}, 32'd1);
        chk("sim d_rdata", d_rdata, 32'h1111_1111);
        wait_access("sim i");
        chk("sim second a", mem_a, 32'h0000_0200);
        reply(32'h2222_2222);
        chk("sim i_rdata", i_rdata, 32'h2222_2222);
        for (int w = 0; w < 4; w++) begin
            chk("sticky if", {31'd0, stallreq_from_if}, 32'd0);
            chk("sticky mem", {31'd0, stallreq_from_mem}, 32'd0);
            @(negedge clk);
            chk("sticky no reissue", {31'd0, mem_access}, 32'd0);
        end
        pipe_adv = 1'b1;
        @(negedge clk);
        pipe_adv = 1'b0; #1;
        chk("adv clr if", {31'd0, stallreq_from_if}, 32'd1);
        chk("adv clr mem", {31'd0, stallreq_from_mem}, 32'd1);
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("adv no grant", {31'd0, mem_access}, 32'd0);

        // Flush while in D_BUSY
        d_req = 1'b1; d_addr = 32'h0000_0040;
        wait_access("flush");
        flush = 1'b1; #1;
        chk("flush stall", {31'd0, stallreq_from_mem}, 32'd0);
        @(negedge clk);
        chk("flush not aborted", {31'd0, mem_access}, 32'd1);
        chk("flush hold a", mem_a, 32'h0000_0040);
        reply(32'h5555_AAAA);
        chk("flush acc drop", {31'd0, mem_access}, 32'd0);
        chk("flush d_rdata", d_rdata, 32'h5555_AAAA);
        @(negedge clk);
        chk("flush no regrant", {31'd0, mem_access}, 32'd0);
        flush = 1'b0; #1;
        chk("flush done clear", {31'd0, stallreq_from_mem}, 32'd1);
        wait_access("flush reissue");
        chk("reissue a", mem_a, 32'h0000_0040);
        reply(32'h0BAD_F00D);
        chk("reissue stall", {31'd0, stallreq_from_mem}, 32'd0);
        advance();

        // Reset mid-fetch
        i_req = 1'b1; i_addr = 32'h0000_0300;
        wait_access("rst fetch");
        rst = 1'b1;
        @(negedge clk);
        chk("rst access", {31'd0, mem_access}, 32'd0);
        chk("rst mem_a", mem_a, 32'd0);
        chk("rst i_rdata", i_rdata, 32'd0);
        chk("rst d_rdata", d_rdata, 32'd0);
        rst = 1'b0; i_req = 1'b0;
        @(negedge clk);
        chk("rst idle", {31'd0, mem_access}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
